l1c_inst_assoc: RTL and testbench



---
 rtl/l1c_pkg.sv | 14 +
 rtl/l1c_victim_sel.sv | 39 +++
 rtl/l1c_inst_assoc.sv | 147 ++++++++++++++
 tb/tb_l1c_inst_assoc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/l1c_pkg.sv
// l1c_pkg: shared state encoding, word type and address-geometry helpers for the instruction cache
package l1c_pkg;
    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, FLUSH} state_t;
    typedef logic [31:0] cache_word_t;
    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - idx_w(sets) - off_w(line_words);
    endfunction
endpackage

// File: rtl/l1c_victim_sel.sv
// l1c_victim_sel: per-set replacement pointers and victim choice for the instruction cache
//   clk, rst          clock, async active-high reset
//   clear             invalidate-all: zero every pointer
//   idx, valid        set under lookup and its per-way valid bits
//   hit, hit_way      lookup hit and the way that hit
//   fill, fill_way    last refill beat and the way being filled
//   victim            way to replace for idx
module l1c_victim_sel
    import l1c_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 32,
    localparam int IW = $clog2(SETS),
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [IW-1:0] idx,
    input  logic [WAYS-1:0] valid,
    input  logic          hit,
    input  logic [WW-1:0] hit_way,
    input  logic          fill,
    input  logic [WW-1:0] fill_way,
    output logic [WW-1:0] victim
);
    logic [WW-1:0] ptr [SETS];
    // an invalid way always beats the pointer; lowest index first
    always_comb begin
        victim = WAYS > 1 ? ptr[idx] : '0;
        for (int w = WAYS - 1; w >= 0; w--) if (!valid[w]) victim = WW'(w);
    end
    // two ways: point at the other way (true LRU); more ways: round-robin on fills only
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '{default: '0};
        else if (clear) ptr <= '{default: '0};
        else if (fill) ptr[idx] <= WAYS == 2 ? ~fill_way : WW'(fill_way + WW'(1));
        else if (hit && WAYS == 2) ptr[idx] <= ~hit_way;
endmodule

// File: rtl/l1c_inst_assoc.sv
// l1c_inst_assoc: N-way set-associative read-only L1 instruction cache
//   clk, rst                    clock, async active-high reset
//   core_req/core_addr          fetch request and word address, held while core_wait
//   core_out/core_wait          instruction word (valid when core_req & ~core_wait), stall
//   flush                       single-cycle invalidate-all pulse
//   I_req/I_addr/I_out/I_wait   refill beat port; a beat completes on I_req & ~I_wait
//   hit_cnt/miss_cnt            saturating performance counters
module l1c_inst_assoc
    import l1c_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output cache_word_t       core_out,
    output logic              core_wait,
    input  logic              flush,
    output logic              I_req,
    output logic [ADDR_W-1:0] I_addr,
    input  cache_word_t       I_out,
    input  logic              I_wait,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int OW = off_w(LINE_WORDS);
    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int BW = OW - 2;
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;

    state_t state, nxt;
    logic [ADDR_W-1:2] req_addr;
    logic [BW-1:0] beat;
    logic [WW-1:0] victim, victim_q, hit_way;
    logic flush_pend;
    cache_word_t out_q;
    logic [TW-1:0] tags [WAYS][SETS];
    cache_word_t data [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0] vld [SETS];
    logic [WAYS-1:0] match;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [BW-1:0] word;
    logic hit, beat_done, last_beat, go_flush, unused_ok;

    assign unused_ok = &{1'b0, core_addr[1:0]};
    assign idx = req_addr[OW +: IW];
    assign tag = req_addr[ADDR_W-1 -: TW];
    assign word = req_addr[2 +: BW];
    assign hit = |match;
    assign beat_done = state == REFILL && !I_wait;
    assign last_beat = beat_done && beat == BW'(LINE_WORDS - 1);
    assign go_flush = flush || flush_pend;

    always_comb begin
        match = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) match[w] = vld[idx][w] && tags[w][idx] == tag;
        for (int w = WAYS - 1; w >= 0; w--) if (match[w]) hit_way = WW'(w);
    end

    always_comb begin
        nxt = state;
        core_wait = 1'b1;
        core_out = out_q;
        I_req = 1'b0;
        I_addr = '0;
        case (state)
            IDLE: begin
                nxt = go_flush ? FLUSH : core_req ? LOOKUP : IDLE;
                core_wait = core_req;
            end
            LOOKUP: begin
                nxt = !hit ? REFILL : go_flush ? FLUSH : IDLE;
                core_wait = !hit;
                core_out = hit ? data[hit_way][idx][word] : out_q;
            end
            REFILL: begin
                nxt = last_beat ? RESP : REFILL;
                I_req = 1'b1;
                I_addr = {req_addr[ADDR_W-1:OW], beat, 2'b00};
            end
            RESP: begin
                nxt = go_flush ? FLUSH : IDLE;
                core_wait = 1'b0;
                core_out = data[victim_q][idx][word];
            end
            default: nxt = IDLE;
        endcase
    end

    // a miss invalidates its victim up front so an interrupted refill never leaves a stale-valid line
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            req_addr <= '0;
            beat <= '0;
            victim_q <= '0;
            flush_pend <= 1'b0;
            out_q <= '0;
            hit_cnt <= '0;
            miss_cnt <= '0;
            vld <= '{default: '0};
        end else begin
            state <= nxt;
            out_q <= core_out;
            flush_pend <= state == FLUSH ? 1'b0 : flush_pend || (flush && state != IDLE);
            if (state == IDLE && nxt == LOOKUP) req_addr <= core_addr[ADDR_W-1:2];
            if (state == LOOKUP && hit && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
            if (state == LOOKUP && !hit) begin
                if (!(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
                victim_q <= victim;
                beat <= '0;
                vld[idx][victim] <= 1'b0;
            end
            if (beat_done) beat <= beat + BW'(1);
            if (last_beat) vld[idx][victim_q] <= 1'b1;
            if (state == FLUSH) vld <= '{default: '0};
        end

    always_ff @(posedge clk) begin
        if (beat_done) data[victim_q][idx][beat] <= I_out;
        if (last_beat) tags[victim_q][idx] <= tag;
    end

    always_ff @(posedge clk)
        if (!rst && state == LOOKUP) assert ($onehot0(match));

    l1c_victim_sel #(.WAYS(WAYS), .SETS(SETS)) u_victim_sel (
        .clk(clk),
        .rst(rst),
        .clear(state == FLUSH),
        .idx(idx),
        .valid(vld[idx]),
        .hit(state == LOOKUP && hit),
        .hit_way(hit_way),
        .fill(last_beat),
        .fill_way(victim_q),
        .victim(victim)
    );
endmodule

// File: tb/tb_l1c_inst_assoc.sv
// tb_l1c_inst_assoc: directed checks of hits, misses, replacement, flush, refill stalls and reset
module tb_l1c_inst_assoc;
    logic clk = 0, rst = 1, core_req = 0, flush = 0, I_wait = 0;
    logic [31:0] core_addr = 0, core_out, I_addr, I_out, hit_cnt, miss_cnt;
    logic core_wait, I_req;
    logic [15:0] salt = 0;
    int errors = 0, checks = 0;
    logic [31:0] d;
    int cyc, nb;

    l1c_inst_assoc dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_addr(core_addr),
        .core_out(core_out), .core_wait(core_wait), .flush(flush),
        .I_req(I_req), .I_addr(I_addr), .I_out(I_out), .I_wait(I_wait),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;
    assign I_out = {16'hC0DE ^ salt, I_addr[15:0]};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int stall_beat, input int flush_beat,
                         output logic [31:0] data, output int cyc, output int nb);
        logic [31:0] base;
        bit done;
        base = {a[31:4], 4'h0};
        done = 0;
        data = '0;
        cyc = 1;
        nb = 0;
        core_addr = a;
        core_req = 1;
        while (!done) begin
            @(negedge clk);
            cyc++;
            flush = 0;
            if (cyc > 100) begin
                check("timeout", 32'(cyc), 32'd100);
                core_req = 0;
                done = 1;
            end else if (!core_wait) begin
                data = core_out;
                core_req = 0;
                done = 1;
            end else if (I_req) begin
                if (nb == flush_beat) flush = 1;
                if (nb == stall_beat) begin
                    I_wait = 1;
                    repeat (5) begin
                        @(negedge clk);
                        cyc++;
                        check("stall_addr", I_addr, base + 32'(4 * nb));
                        check("stall_req", 32'(I_req), 32'd1);
                    end
                    I_wait = 0;
                end
                check("beat_addr", I_addr, base + 32'(4 * nb));
                nb++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_core_out", core_out, 0);
        check("rst_ireq", 32'(I_req), 0);
        check("rst_iaddr", I_addr, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_wait_idle", 32'(core_wait), 0);
        core_req = 1;
        #1 check("wait_follows_req", 32'(core_wait), 1);
        core_req = 0;
        @(negedge clk);

        fetch(32'h104, -1, -1, d, cyc, nb);
        check("cold_data", d, 32'hC0DE0104);
        check("cold_cyc", 32'(cyc), 7);
        check("cold_beats", 32'(nb), 4);
        check("cold_miss", miss_cnt, 1);
        check("cold_hit", hit_cnt, 0);

        fetch(32'h108, -1, -1, d, cyc, nb);
        check("hit_data", d, 32'hC0DE0108);
        check("hit_cyc", 32'(cyc), 2);
        check("hit_no_ireq", 32'(nb), 0);
        check("hit_cnt1", hit_cnt, 1);

        fetch(32'h000, -1, -1, d, cyc, nb);
        check("fill0_beats", 32'(nb), 4);
        fetch(32'h200, -1, -1, d, cyc, nb);
        check("fill200_data", d, 32'hC0DE0200);
        check("fill200_beats", 32'(nb), 4);
        fetch(32'h004, -1, -1, d, cyc, nb);
        check("touch0_data", d, 32'hC0DE0004);
        check("touch0_hit", 32'(nb), 0);
        fetch(32'h400, -1, -1, d, cyc, nb);
        check("fill400_beats", 32'(nb), 4);
        fetch(32'h00C, -1, -1, d, cyc, nb);
        check("re0_hit", 32'(nb), 0);
        check("re0_data", d, 32'hC0DE000C);
        fetch(32'h200, -1, -1, d, cyc, nb);
        check("re200_miss", 32'(nb), 4);
        check("lru_miss", miss_cnt, 5);
        check("lru_hit", hit_cnt, 3);

        fetch(32'h30C, -1, 1, d, cyc, nb);
        check("flush_data", d, 32'hC0DE030C);
        check("flush_cyc", 32'(cyc), 7);
        salt = 16'h0001;
        fetch(32'h30C, -1, -1, d, cyc, nb);
        check("post_flush_miss", 32'(nb), 4);
        check("post_flush_data", d, 32'hC0DF030C);
        fetch(32'h108, -1, -1, d, cyc, nb);
        check("post_flush_other", 32'(nb), 4);
        check("post_flush_other_data", d, 32'hC0DF0108);

        fetch(32'h50C, 2, -1, d, cyc, nb);
        check("stall_data", d, 32'hC0DF050C);
        check("stall_cyc", 32'(cyc), 12);
        for (int i = 0; i < 3; i++) begin
            fetch(32'h500 + 32'(4 * i), -1, -1, d, cyc, nb);
            check("stall_line_data", d, 32'hC0DF0500 + 32'(4 * i));
            check("stall_line_hit", 32'(cyc), 2);
        end

        flush = 1;
        fetch(32'h500, -1, -1, d, cyc, nb);
        check("flush_wins_beats", 32'(nb), 4);
        check("flush_wins_cyc", 32'(cyc), 9);
        check("flush_wins_data", d, 32'hC0DF0500);
        check("total_miss", miss_cnt, 10);
        check("total_hit", hit_cnt, 6);

        core_addr = 32'h600;
        core_req = 1;
        for (int i = 0; i < 20 && !(I_req && I_addr == 32'h604); i++) @(negedge clk);
        check("rst_reach_beat", I_addr, 32'h604);
        rst = 1;
        #1;
        check("rst_mid_ireq", 32'(I_req), 0);
        check("rst_mid_iaddr", I_addr, 0);
        check("rst_mid_hit", hit_cnt, 0);
        check("rst_mid_miss", miss_cnt, 0);
        core_req = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        fetch(32'h600, -1, -1, d, cyc, nb);
        check("after_rst_miss", 32'(nb), 4);
        check("after_rst_cyc", 32'(cyc), 7);
        check("after_rst_data", d, 32'hC0DF0600);
        check("after_rst_cnt", miss_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
